// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default sizing for the PWM duty decoder
// No ports; provides state_t, DEF_WIDTH and DEF_TIMEOUT.
package pwm_pkg;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_TIMEOUT = 2047;
    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;
endpackage

// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: PWM input and measurement results bundled between source and decoder
// Signals: pwm_in (to decoder), duty, period, valid, stuck (from decoder).
// Modports: master = PWM source / consumer side, slave = decoder side.
interface pwm_duty_decoder_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             pwm_in;
    logic [WIDTH-1:0] duty;
    logic [WIDTH:0]   period;
    logic             valid;
    logic             stuck;
    modport master (output pwm_in, input duty, period, valid, stuck);
    modport slave  (input pwm_in, output duty, period, valid, stuck);
endinterface

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronizes the async PWM input and flags its rising edges
// Ports: clk, reset (sync, active-high), pwm_in (async) -> s (synchronized level), rise (edge strobe).
// Config: PWM_ACTIVE_LOW_EN inverts the synchronized level so low-active drive reads as on-time.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= s;
        end
    end
`ifdef PWM_ACTIVE_LOW_EN
    assign s = ~sync[SYNC_STAGES-1];
`else
    assign s = sync[SYNC_STAGES-1];
`endif
    assign rise = s & ~prev;
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and period of a PWM input between rising edges
// Ports: clk, reset (sync, active-high), bus (slave): pwm_in -> duty, period, valid, stuck.
// Config: PWM_ACTIVE_LOW_EN (in pwm_edge_sync) measures low time of pwm_in instead of high time.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 reset,
    pwm_duty_decoder_if.slave   bus
);
    localparam logic [WIDTH:0]   TMO   = (WIDTH+1)'(TIMEOUT);
    localparam logic [WIDTH:0]   P_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] H_ONE = WIDTH'(1);
    state_t           state, state_n;
    logic [WIDTH:0]   pcnt, pcnt_n, pcnt_inc, period_n;
    logic [WIDTH-1:0] hcnt, hcnt_n, hcnt_inc, duty_n;
    logic             valid_n, stuck_n, s, rise;
    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (bus.pwm_in),
        .s      (s),
        .rise   (rise)
    );
    assign pcnt_inc = &pcnt ? pcnt : pcnt + 1'b1;
    assign hcnt_inc = &hcnt ? hcnt : hcnt + 1'b1;
    always_comb begin
        state_n  = state;
        pcnt_n   = pcnt;
        hcnt_n   = hcnt;
        duty_n   = bus.duty;
        period_n = bus.period;
        stuck_n  = bus.stuck;
        valid_n  = 1'b0;
        // a rise always restarts measurement; only MEASURE owns a complete period to report
        if (rise) begin
            state_n = MEASURE;
            pcnt_n  = P_ONE;
            hcnt_n  = H_ONE;
            if (state == MEASURE) begin
                period_n = pcnt;
                duty_n   = hcnt;
                valid_n  = 1'b1;
                stuck_n  = 1'b0;
            end
        end else if (state != STUCK) begin
            if (pcnt == TMO) begin
                state_n  = STUCK;
                stuck_n  = 1'b1;
                period_n = '0;
                duty_n   = s ? '1 : '0;
                valid_n  = 1'b1;
            end else begin
                pcnt_n = pcnt_inc;
                hcnt_n = (state == MEASURE && s) ? hcnt_inc : hcnt;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            bus.duty   <= '0;
            bus.period <= '0;
            bus.valid  <= 1'b0;
            bus.stuck  <= 1'b0;
        end else begin
            state      <= state_n;
            pcnt       <= pcnt_n;
            hcnt       <= hcnt_n;
            bus.duty   <= duty_n;
            bus.period <= period_n;
            bus.valid  <= valid_n;
            bus.stuck  <= stuck_n;
        end
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: randomized and directed stimulus checked against a timestamp-based model
module tb_pwm_duty_decoder;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 2047;
    localparam int HMAX    = 1023;
`ifdef PWM_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   nv = 0;
    pwm_duty_decoder_if bus ();
    pwm_duty_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // model: s(j) is the input seen SYNC cycles after it was driven; a period is the
    // distance between two rise timestamps, duty the count of high cycles in between
    bit   hist[$];
    int   cyc, refc, hi, e_duty, e_period;
    bit   armed, stk, s_prev, e_valid, e_stuck, sj;
    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            cyc = 0; refc = 0; hi = 0; armed = 0; stk = 0; s_prev = 0;
            e_duty = 0; e_period = 0; e_valid = 0; e_stuck = 0;
        end else begin
            check("duty", 64'(bus.duty), 64'(e_duty));
            check("period", 64'(bus.period), 64'(e_period));
            check("valid", 64'(bus.valid), 64'(e_valid));
            check("stuck", 64'(bus.stuck), 64'(e_stuck));
            hist.push_back(bus.pwm_in);
            sj = (cyc < SYNC ? 1'b0 : hist[cyc-SYNC]) ^ INV;
            e_valid = 0;
            if (sj && !s_prev) begin
                if (armed) begin
                    e_period = cyc - refc;
                    e_duty = hi > HMAX ? HMAX : hi;
                    e_valid = 1;
                    e_stuck = 0;
                end
                armed = 1; stk = 0; refc = cyc; hi = 0;
            end else if (!stk && cyc - refc == TIMEOUT) begin
                stk = 1; armed = 0;
                e_stuck = 1; e_period = 0; e_duty = sj ? HMAX : 0; e_valid = 1;
            end
            if (sj) hi++;
            s_prev = sj;
            cyc++;
        end
    end
    task automatic tick(input bit on);
        @(posedge clk);
        #1 bus.pwm_in = on ^ INV;
        @(negedge clk);
        nv += int'(bus.valid);
    endtask
    task automatic wave(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++) tick(i < h);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        bus.pwm_in = INV;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int lat, n, h;
        bus.pwm_in = INV;
        do_reset();
        check("rst_duty", 64'(bus.duty), 0);
        check("rst_period", 64'(bus.period), 0);
        check("rst_valid", 64'(bus.valid), 0);
        check("rst_stuck", 64'(bus.stuck), 0);
        repeat (2060) tick(1'b0);
        check("idle_stuck", 64'(bus.stuck), 1);
        check("idle_duty", 64'(bus.duty), 0);
        check("idle_period", 64'(bus.period), 0);
        wave(1024, 300, 1);
        lat = -1;
        for (int k = 0; k < 1024; k++) begin
            tick(k < 300);
            if (bus.valid && lat < 0) lat = k;
        end
        check("latency", 64'(lat), 3);
        wave(1024, 300, 2);
        check("p1024_duty", 64'(bus.duty), 300);
        check("p1024_period", 64'(bus.period), 1024);
        check("p1024_stuck", 64'(bus.stuck), 0);
        nv = 0;
        repeat (2100) tick(1'b1);
        check("high_valids", 64'(nv), 2);
        check("high_stuck", 64'(bus.stuck), 1);
        check("high_duty", 64'(bus.duty), 1023);
        check("high_period", 64'(bus.period), 0);
        wave(1024, 300, 3);
        check("recover_stuck", 64'(bus.stuck), 0);
        check("recover_duty", 64'(bus.duty), 300);
        check("recover_period", 64'(bus.period), 1024);
        wave(1600, 1500, 3);
        check("sat_duty", 64'(bus.duty), 1023);
        check("sat_period", 64'(bus.period), 1600);
        wave(1024, 300, 1);
        repeat (200) tick(1'b1);
        do_reset();
        check("midrst_duty", 64'(bus.duty), 0);
        check("midrst_period", 64'(bus.period), 0);
        nv = 0;
        wave(1024, 300, 2);
        check("midrst_valids", 64'(nv), INV ? 2 : 1);
        check("midrst_duty2", 64'(bus.duty), 300);
        check("midrst_period2", 64'(bus.period), 1024);
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(1800, 2);
            h = $urandom_range(n - 1, 1);
            wave(n, h, 3);
            if ($urandom_range(3, 0) == 0) repeat (2100) tick(1'($urandom_range(1, 0)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive end of the LED PWM path: it recovers the 10-bit compare value that a counter/comparator PWM generator encodes, for loopback self-check or for driving LEDs from an external PWM source. The block synchronizes the input, detects rising edges, counts period and high cycles between edges, and flags a stuck input.

## Interface
- `WIDTH`, 10: width of `duty`; `period` is WIDTH+1 bits.
- `SYNC_STAGES`, 2: input synchronizer depth (≥2).
- `TIMEOUT`, 2047: cycles without a rising edge before stuck is declared; must be ≤ 2^(WIDTH+1)-1.

- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pwm_in` input 1: asynchronous PWM input.
- `duty` output WIDTH: high cycles in last period, saturating at 2^WIDTH-1.
- `period` output WIDTH+1: cycles between last two rising edges; 0 after timeout.
- `valid` output 1: one-cycle pulse when `duty`/`period`/`stuck` update.
- `stuck` output 1: input held static for TIMEOUT cycles.

## Operation
- `s` = last synchronizer stage (after optional inversion, see Configuration); `prev` = `s` delayed one cycle; `rise` = `s & ~prev`.
- Internal counters `pcnt` (WIDTH+1 bits) and `hcnt` (WIDTH bits), both saturating.
- States: IDLE, MEASURE, STUCK.
  - IDLE (reset state): `pcnt` increments each cycle. On `rise`: `pcnt<=1`, `hcnt<=1`, go MEASURE, no `valid`. On `pcnt==TIMEOUT`: go STUCK.
  - MEASURE: `pcnt` increments; `hcnt` increments when `s`=1. On `rise`: `period<=pcnt`, `duty<=hcnt`, `valid<=1`, `stuck<=0`, `pcnt<=1`, `hcnt<=1`, stay. On `pcnt==TIMEOUT` without `rise`: go STUCK.
  - Entering STUCK: `stuck<=1`, `period<=0`, `duty <= s ? 2^WIDTH-1 : 0`, `valid<=1` (once). In STUCK counters hold; on `rise`: `pcnt<=1`, `hcnt<=1`, go MEASURE (stuck clears at next MEASURE capture).
- `rise` and timeout in same cycle: `rise` wins.
- A waveform of period N, high H (H<N) yields `period`=N, `duty`=min(H, 2^WIDTH-1).

## Timing
- Reset values: `duty`=0, `period`=0, `valid`=0, `stuck`=0, state IDLE, counters 0, synchronizer and `prev` cleared to 0.
- Latency: `pwm_in` first sampled high at edge k → `valid` high in the cycle after edge k+SYNC_STAGES (one cycle wide).
- Outputs hold between `valid` pulses.
- Reset mid-period discards the partial measurement; the first rise after reset only arms.
- Consecutive `valid` pulses are separated by at least 2 cycles (minimum detectable period 2).

## Configuration
- `PWM_ACTIVE_LOW_EN`: when defined, the synchronized input is inverted before edge detection, so an active-low LED drive (low = on) decodes to on-time in `duty`. When undefined, `pwm_in` high counts as high time. Synchronizer reset value is always 0 pre-inversion.

## Structure
- `pwm_pkg`: state enum (IDLE, MEASURE, STUCK), default WIDTH constant (10), default TIMEOUT constant.
- Sub-module `pwm_edge_sync`: SYNC_STAGES flop chain, optional inversion, `prev` register, outputs `s` and `rise`.

## Test plan
- Reset then no activity: all outputs 0; after 2047 cycles of low input → `valid` pulse, `stuck`=1, `duty`=0, `period`=0.
- Period-1024 waveform, high 300 cycles: second rise onward → `valid` every 1024 cycles, `duty`=300, `period`=1024, `stuck`=0; first `valid` SYNC_STAGES cycles after second edge.
- Input held high 2047+ cycles after one rise → `stuck`=1, `duty`=1023, single `valid`; next rise then a full period → `stuck`=0, correct values.
- High time 1500 cycles in period 1600 → `duty`=1023 (saturated), `period`=1600.
- Reset asserted mid-period of a 1024/300 waveform → outputs 0 next cycle; first post-reset rise gives no `valid`; second gives `duty`=300.
- With `PWM_ACTIVE_LOW_EN` defined, input low 300 of 1024 cycles → `duty`=300, `period`=1024 (timed from falling edges of `pwm_in`).
